// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte buffer between uart_rx and a consumer that may stall.
// Captures push_data on each push strobe, hands bytes out in arrival order,
// reports occupancy and latches a sticky overrun when a byte is dropped.
// Optional build macro UART_RX_FIFO_FWFT_EN selects first-word fall-through
// read data; without it pop_data is a register loaded on an accepted pop.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [DATA_W-1:0]     pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int                  DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_ONE  = (DEPTH_LOG2 + 1)'(1);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun;

  logic w_empty;
  logic w_full;
  logic w_push_acc;
  logic w_pop_acc;
  logic w_drop;

  // Flags come from the registered count so they only move on an edge or reset.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);

  // A push into a full buffer still fits when a pop frees a slot the same cycle.
  assign w_pop_acc  = pop && !w_empty;
  assign w_push_acc = push && (!w_full || pop);
  assign w_drop     = push && !w_push_acc;

  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;

  // Storage array; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wp] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push_acc) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop_acc) begin
        r_rp <= r_rp + 1'b1;
      end
    end
  end

  // Occupancy: +1 on push only, -1 on pop only, hold when both or neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else begin
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  // Fall-through: head entry is visible whenever something is stored.
  assign pop_data = w_empty ? '0 : r_mem[r_rp];
`else
  logic [DATA_W-1:0] r_pop_data;

  // Registered read: load the head entry on an accepted pop, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pop_data <= '0;
    end else if (w_pop_acc) begin
      r_pop_data <= r_mem[r_rp];
    end
  end

  assign pop_data = r_pop_data;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (default 8-bit x 16 entries).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. A queue holds the bytes the FIFO should contain.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb[$];
  logic       m_ovr;
  logic [7:0] m_pd;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // One clock of stimulus; updates the reference model at the rising edge.
  task automatic step(input logic p, input logic [7:0] d, input logic q,
                      input logic c, output logic [7:0] popped,
                      output logic [7:0] got);
    logic pa, wa;
    @(negedge clk);
    push = p; push_data = d; pop = q; clr_overrun = c;
    #1;
`ifdef UART_RX_FIFO_FWFT_EN
    got = pop_data;
`endif
    @(posedge clk);
    pa = q && (sb.size() != 0);
    wa = p && ((sb.size() < 16) || q);
    popped = 8'h00;
    if (pa) begin
      popped = sb.pop_front();
      m_pd   = popped;
    end
    if (wa) sb.push_back(d);
    if (p && !wa) m_ovr = 1'b1;
    else if (c)   m_ovr = 1'b0;
    #1;
`ifndef UART_RX_FIFO_FWFT_EN
    got = pop_data;
`endif
    push = 1'b0; pop = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; push = 0; pop = 0; push_data = 0; clr_overrun = 0;
    sb.delete(); m_ovr = 0; m_pd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({empty, full, count, overrun, pop_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got empty=%b full=%b count=%0d ovr=%b pd=%h, want 1 0 0 0 00",
               empty, full, count, overrun, pop_data);
    end
  endtask

  task automatic test_order();
    logic [7:0] pats [3];
    logic [7:0] exp, got;
    pats[0] = 8'h55; pats[1] = 8'hA3; pats[2] = 8'h00;
    for (int i = 0; i < 3; i++) step(1'b1, pats[i], 1'b0, 1'b0, exp, got);
    n_checks++;
    if (count !== 5'd3 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL order_fill: got count=%0d empty=%b, want 3 0", count, empty);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
      n_checks++;
      if (got !== exp || exp !== pats[i]) begin
        n_fail++;
        $display("FAIL order_pop%0d: got %h, want %h", i, got, pats[i]);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL order_empty: got empty=%b count=%0d, want 1 0", empty, count);
    end
  endtask

  task automatic test_empty_pop();
    logic [7:0] exp, got;
    step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
    n_checks++;
`ifdef UART_RX_FIFO_FWFT_EN
    if (pop_data !== 8'h00 || count !== 5'd0 || overrun !== 1'b0) begin
`else
    if (pop_data !== m_pd || count !== 5'd0 || overrun !== 1'b0) begin
`endif
      n_fail++;
      $display("FAIL empty_pop: got pd=%h count=%0d ovr=%b, want pd=%h 0 0",
               pop_data, count, overrun, m_pd);
    end
    step(1'b1, 8'h9E, 1'b1, 1'b0, exp, got);
    n_checks++;
    if (count !== 5'd1 || empty !== 1'b0 || sb.size() != 1) begin
      n_fail++;
      $display("FAIL empty_pushpop: got count=%0d empty=%b, want 1 0", count, empty);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
    n_checks++;
    if (got !== 8'h9E || count !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_pushpop_data: got %h count=%0d, want 9e 0", got, count);
    end
  endtask

  task automatic test_full_overrun();
    logic [7:0] exp, got;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, exp, got);
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fill: got full=%b count=%0d ovr=%b, want 1 16 0", full, count, overrun);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0, exp, got);
    n_checks++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1 || m_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drop: got full=%b count=%0d ovr=%b, want 1 16 1", full, count, overrun);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
      n_checks++;
      if (got !== 8'(i) || got === 8'hFF) begin
        n_fail++;
        $display("FAIL full_drain%0d: got %h, want %h", i, got, 8'(i));
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, exp, got);
    n_checks++;
    if (overrun !== 1'b0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL full_clr: got ovr=%b empty=%b, want 0 1", overrun, empty);
    end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp, got;
    for (int i = 0; i < 16; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, exp, got);
    step(1'b1, 8'h77, 1'b1, 1'b0, exp, got);
    n_checks++;
    if (count !== 5'd16 || overrun !== 1'b0 || got !== 8'h40) begin
      n_fail++;
      $display("FAIL fullpp_flags: got count=%0d ovr=%b pd=%h, want 16 0 40", count, overrun, got);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fullpp_drain%0d: got %h, want %h", i, got, exp);
      end
    end
    n_checks++;
    if (got !== 8'h77 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_last: got %h empty=%b, want 77 1", got, empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp, got;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'hA0 + 8'(r * 16 + i), 1'b0, 1'b0, exp, got);
      n_checks++;
      if (count !== 5'd10) begin
        n_fail++;
        $display("FAIL wrap_fill%0d: got count=%0d, want 10", r, count);
      end
      if (r == 1) break;
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
        n_checks++;
        if (got !== 8'hA0 + 8'(i)) begin
          n_fail++;
          $display("FAIL wrap_pop%0d: got %h, want %h", i, got, 8'hA0 + 8'(i));
        end
      end
      n_checks++;
      if (count !== 5'd0) begin
        n_fail++;
        $display("FAIL wrap_drain: got count=%0d, want 0", count);
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
      n_checks++;
      if (got !== 8'hB0 + 8'(i)) begin
        n_fail++;
        $display("FAIL wrap_pop2_%0d: got %h, want %h", i, got, 8'hB0 + 8'(i));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp, got;
    for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, exp, got);
    step(1'b1, 8'hEE, 1'b1, 1'b0, exp, got);
    step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
    n_checks++;
    if (count !== 5'd5) begin
      n_fail++;
      $display("FAIL arst_pre: got count=%0d, want 5", count);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    sb.delete(); m_ovr = 0; m_pd = 0;
    #1;
    n_checks++;
    if ({empty, full, count, overrun, pop_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL arst_immediate: got empty=%b full=%b count=%0d ovr=%b pd=%h, want 1 0 0 0 00",
               empty, full, count, overrun, pop_data);
    end
    @(negedge clk); rst = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0, exp, got);
    step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
    n_checks++;
    if (got !== 8'h3C || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_after: got %h empty=%b, want 3c 1", got, empty);
    end
  endtask

  task automatic test_clr_conflict();
    logic [7:0] exp, got;
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, exp, got);
    step(1'b1, 8'h5A, 1'b0, 1'b1, exp, got);
    n_checks++;
    if (overrun !== 1'b1 || overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL clr_conflict: got ovr=%b, want 1", overrun);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, exp, got);
    n_checks++;
    if (overrun !== 1'b0 || count !== 5'd16) begin
      n_fail++;
      $display("FAIL clr_alone: got ovr=%b count=%0d, want 0 16", overrun, count);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, exp, got);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL clr_drain%0d: got %h, want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_empty_pop();
    test_full_overrun();
    test_full_pushpop();
    test_wrap();
    test_async_reset();
    test_clr_conflict();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
